// File: rtl/uart_boot_loader.sv
// UART 8N1 program loader: receives a length-prefixed, XOR-checksummed image, writes it
// word-by-word into instruction memory and releases the core only after the image verifies.
//
// rx state | meaning
// RX_IDLE  | line idle, waiting for a synchronized falling edge
// RX_START | timing to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit; high -> byte_valid, low -> framing error
//
// ld state | meaning
// LD_LEN0  | expecting word count low byte
// LD_LEN1  | expecting word count high byte, range check
// LD_DATA  | assembling payload words and writing them out
// LD_CSUM  | expecting checksum byte
// LD_DONE  | image verified, core released, input ignored
// LD_ERR   | error latched, core held, input ignored until rst
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM, LD_DONE, LD_ERR} ld_state_t;

  logic rx_meta, rx_sync, rx_prev;

  rx_state_t        rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_bit_idx, rx_bit_idx_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic [7:0]       rx_byte, rx_byte_d;
  logic             byte_valid, byte_valid_d;
  logic             frame_err;

  ld_state_t        ld_state, ld_state_d;
  logic [15:0]      word_cnt, word_cnt_d;
  logic [ADDR_W:0]  word_idx, word_idx_d, word_idx_inc;
  logic [7:0]       csum, csum_d;
  logic [1:0]       byte_sel, byte_sel_d;
  logic [23:0]      word_buf, word_buf_d;
  logic             wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]      wr_data_d;
  logic [15:0]      len_full;

  // Synchronizer resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit_idx <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit_idx <= rx_bit_idx_d;
      rx_shift   <= rx_shift_d;
      rx_byte    <= rx_byte_d;
      byte_valid <= byte_valid_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_bit_idx_d = rx_bit_idx;
    rx_shift_d   = rx_shift;
    rx_byte_d    = rx_byte;
    byte_valid_d = 1'b0;
    frame_err    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_d   = RX_START;
          rx_cnt_d     = HALF_LAST;
          rx_bit_idx_d = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_sync) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_idx == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_idx_d = rx_bit_idx + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_d = RX_IDLE;
          if (rx_sync) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = rx_shift;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state     <= LD_LEN0;
      word_cnt     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      byte_sel     <= '0;
      word_buf     <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      ld_state     <= ld_state_d;
      word_cnt     <= word_cnt_d;
      word_idx     <= word_idx_d;
      csum         <= csum_d;
      byte_sel     <= byte_sel_d;
      word_buf     <= word_buf_d;
      imem_wr_en   <= wr_en_d;
      imem_wr_addr <= wr_addr_d;
      imem_wr_data <= wr_data_d;
      cpu_rst_n    <= (ld_state_d == LD_DONE);
      load_done    <= (ld_state_d == LD_DONE);
      load_err     <= (ld_state_d == LD_ERR);
    end
  end

  assign word_idx_inc = word_idx + 1'b1;
  assign len_full     = {rx_byte, word_cnt[7:0]};

  always_comb begin
    ld_state_d = ld_state;
    word_cnt_d = word_cnt;
    word_idx_d = word_idx;
    csum_d     = csum;
    byte_sel_d = byte_sel;
    word_buf_d = word_buf;
    wr_en_d    = 1'b0;
    wr_addr_d  = imem_wr_addr;
    wr_data_d  = imem_wr_data;
    case (ld_state)
      LD_LEN0: begin
        if (byte_valid) begin
          word_cnt_d[7:0] = rx_byte;
          ld_state_d      = LD_LEN1;
        end
      end
      LD_LEN1: begin
        if (byte_valid) begin
          word_cnt_d[15:8] = rx_byte;
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) begin
            ld_state_d = LD_ERR;
          end else begin
            ld_state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (byte_valid) begin
          csum_d     = csum ^ rx_byte;
          byte_sel_d = byte_sel + 1'b1;
          if (byte_sel == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = word_idx[ADDR_W-1:0];
            wr_data_d  = {rx_byte, word_buf};
            word_idx_d = word_idx_inc;
            if (17'(word_idx_inc) == 17'(word_cnt)) begin
              ld_state_d = LD_CSUM;
            end
          end else begin
            word_buf_d = {rx_byte, word_buf[23:8]};
          end
        end
      end
      LD_CSUM: begin
        if (byte_valid) begin
          ld_state_d = (rx_byte == csum) ? LD_DONE : LD_ERR;
        end
      end
      LD_DONE: ld_state_d = LD_DONE;
      LD_ERR:  ld_state_d = LD_ERR;
      default: ld_state_d = LD_ERR;
    endcase
    // A broken frame poisons the image unless it has already been accepted.
    if (frame_err && ld_state != LD_DONE) begin
      ld_state_d = LD_ERR;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives 8N1 frames and checks writes and status against an
// image-level model that parses the byte stream sent so far.
module tb_uart_boot_loader;
  localparam int CPB  = 8;
  localparam int AW   = 4;
  localparam int MAXW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_wr_en;
  logic [AW-1:0] imem_wr_addr;
  logic [31:0]   imem_wr_data;
  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .cpu_rst_n(cpu_rst_n),
    .load_done(load_done),
    .load_err(load_err)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] stream[$];
  bit         bad[$];
  int         wr_count = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_data = '0;
  int  cmp_nw;
  bit  cmp_done, cmp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Image-level view of everything sent since the last reset.
  function automatic void parse(output int nw, output bit done, output bit err);
    int len, first_bad, n, cidx;
    logic [7:0] x;
    len = stream.size();
    first_bad = len;
    nw = 0; done = 0; err = 0;
    for (int i = 0; i < len; i++) begin
      if (bad[i]) begin
        first_bad = i;
        break;
      end
    end
    if (first_bad < 2) begin
      err = (first_bad < len);
      return;
    end
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n == 0 || n > MAXW) begin
      err = 1;
      return;
    end
    nw = (first_bad - 2) / 4;
    if (nw > n) nw = n;
    cidx = 2 + 4 * n;
    if (first_bad > cidx) begin
      x = 8'h00;
      for (int i = 2; i < cidx; i++) x = x ^ stream[i];
      done = (x == stream[cidx]);
      err  = !done;
    end else begin
      err = (first_bad < len);
    end
  endfunction

  function automatic logic [31:0] model_word(input int k);
    return {stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]};
  endfunction

  function automatic logic [7:0] image_csum(input logic [31:0] w[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (w[i]) x = x ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      wr_count = 0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      if (imem_wr_en) begin
        parse(cmp_nw, cmp_done, cmp_err);
        chk("write_expected", 32'(wr_count < cmp_nw), 32'd1);
        if (wr_count < cmp_nw) begin
          exp_addr = wr_count[AW-1:0];
          exp_data = model_word(wr_count);
        end
        wr_count++;
      end
      chk("wr_addr", 32'(imem_wr_addr), 32'(exp_addr));
      chk("wr_data", imem_wr_data, exp_data);
    end
  end

  task automatic settle_check();
    int nw;
    bit d, e;
    parse(nw, d, e);
    chk("wr_count", wr_count, nw);
    chk("load_done", 32'(load_done), 32'(d));
    chk("load_err", 32'(load_err), 32'(e));
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(d));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    stream.push_back(b);
    bad.push_back(!stop_ok);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    settle_check();
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    stream.delete();
    bad.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
    chk("rst_wr_data", imem_wr_data, 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    @(posedge clk);
    rst = 1'b0;
  endtask

  task automatic send_image(input logic [15:0] n, input logic [31:0] w[$], input logic [7:0] cs,
                            input int bad_idx, input int rst_idx);
    logic [7:0] bytes[$];
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    foreach (w[i]) for (int j = 0; j < 4; j++) bytes.push_back(w[i][8*j +: 8]);
    bytes.push_back(cs);
    foreach (bytes[i]) begin
      if (i == rst_idx) begin
        do_reset();
        return;
      end
      send_byte(bytes[i], i != bad_idx);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] w2[$];
    logic [7:0]  cs;
    int n, bad_idx, rst_idx, nbytes;

    w = '{32'h00500093, 32'h00108113};
    cs = image_csum(w);
    // The XOR of 93 00 50 00 13 81 10 00 works out to 0x41.
    chk("model_csum_img", 32'(cs), 32'h41);
    w2 = '{32'hDEADBEEF};
    chk("model_csum_beef", 32'(image_csum(w2)), 32'h22);

    // Good two-word image, then stray bytes after DONE (including a broken frame).
    do_reset();
    send_image(16'd2, w, cs, -1, -1);
    chk("img1_done", 32'(load_done), 32'd1);
    chk("img1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("img1_writes", wr_count, 32'd2);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b1);
    chk("img1_done_sticky", 32'(load_done), 32'd1);

    // Same image, wrong checksum.
    do_reset();
    send_image(16'd2, w, 8'h38, -1, -1);
    chk("img2_err", 32'(load_err), 32'd1);
    chk("img2_done", 32'(load_done), 32'd0);
    chk("img2_writes", wr_count, 32'd2);

    // Length one beyond capacity, then zero length.
    do_reset();
    send_byte(8'd17, 1'b1);
    send_byte(8'd0, 1'b1);
    chk("len17_err", 32'(load_err), 32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    chk("len17_writes", wr_count, 32'd0);
    do_reset();
    send_byte(8'd0, 1'b1);
    send_byte(8'd0, 1'b1);
    chk("len0_err", 32'(load_err), 32'd1);

    // Short low glitch in idle, then a one-word image.
    do_reset();
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_err", 32'(load_err), 32'd0);
    chk("glitch_writes", wr_count, 32'd0);
    w2 = '{32'h12345678};
    send_image(16'd1, w2, image_csum(w2), -1, -1);
    chk("glitch_then_done", 32'(load_done), 32'd1);

    // Broken stop bit on the third payload byte.
    do_reset();
    send_image(16'd2, w, cs, 4, -1);
    chk("frame_err", 32'(load_err), 32'd1);
    chk("frame_writes", wr_count, 32'd0);

    // Reset after six payload bytes, then a clean DEADBEEF image.
    do_reset();
    send_image(16'd2, w, cs, -1, 8);
    w2 = '{32'hDEADBEEF};
    send_image(16'd1, w2, 8'h22, -1, -1);
    chk("beef_done", 32'(load_done), 32'd1);
    chk("beef_writes", wr_count, 32'd1);
    chk("beef_addr", 32'(imem_wr_addr), 32'd0);
    chk("beef_data", imem_wr_data, 32'hDEADBEEF);

    // Full-capacity image.
    do_reset();
    w.delete();
    for (int i = 0; i < MAXW; i++) w.push_back($urandom);
    send_image(16'(MAXW), w, image_csum(w), -1, -1);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_writes", wr_count, MAXW);

    // Randomized images with occasional corruption, framing errors and resets.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) n = MAXW;
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      cs = image_csum(w);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXW + 1, 300);
      nbytes = 2 + 4 * w.size() + 1;
      bad_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nbytes - 1) : -1;
      rst_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(1, nbytes - 1) : -1;
      send_image(16'(n), w, cs, bad_idx, rst_idx);
      for (int i = 0; i < $urandom_range(0, 2); i++) send_byte(8'($urandom), $urandom_range(0, 3) != 0);
    end

    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
